// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction fetch stage with a DEPTH-entry prefetch queue
// between a 1-cycle-latency instruction memory and decode.
module fetch_prefetch #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       pc,
    output logic [31:0]       command,
    output logic [4:0]        jr_reg,
    output logic              inst_en,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   ifl_pc_q, ifl_pc_d;
    logic          ifl_v_q, ifl_v_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   cmd_mem_q [DEPTH];
    logic          pop, push;
    logic [CW:0]   occ;

    always_comb begin
        out_valid = count_q != '0;
        pop       = out_valid & out_ready;
        push      = ifl_v_q & ~redirect;
        // Occupancy after this cycle's pop, counting the word still in flight
        occ       = (CW+1)'(count_q) + (CW+1)'(ifl_v_q) - (CW+1)'(pop);
        inst_en   = rstn & ~redirect & (occ < (CW+1)'(DEPTH));
        inst_addr = fpc_q[ADDR_W+1:2];
        pc        = out_valid ? pc_mem_q[rptr_q] : '0;
        command   = out_valid ? cmd_mem_q[rptr_q] : '0;
        jr_reg    = command[25:21];
        fpc_d     = redirect ? {redirect_pc[31:2], 2'b00} : inst_en ? fpc_q + 32'd4 : fpc_q;
        ifl_v_d   = inst_en;
        ifl_pc_d  = inst_en ? fpc_q : ifl_pc_q;
        count_d   = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        rptr_d    = redirect ? '0 : rptr_q + PW'(pop);
        wptr_d    = redirect ? '0 : wptr_q + PW'(push);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fpc_q    <= RESET_PC;
            ifl_pc_q <= '0;
            ifl_v_q  <= 1'b0;
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            ifl_pc_q <= ifl_pc_d;
            ifl_v_q  <= ifl_v_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q]  <= ifl_pc_q;
            cmd_mem_q[wptr_q] <= inst_data;
        end
    end

    a_occupancy: assert property (@(posedge clk) disable iff (!rstn)
        ((CW+1)'(count_q) + (CW+1)'(ifl_v_q)) <= (CW+1)'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
        push |-> (count_q != CW'(DEPTH)) || pop);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn)
        pop |-> count_q != '0);
endmodule
